dm_load_unit: RTL and testbench
===============================

Name: dm_load_unit

Overview:
- Load-side reader for the 4 KiB word-organised data memory: the byte, halfword and word load path paired with the memory's sw/sb write path.
- Accepts a byte-addressed load request over a valid/ready handshake.
- Reads one or two memory words through the memory's combinational read port, extracts the addressed lanes (little-endian: byte offset 0 = bits 7:0), then sign- or zero-extends.
- Returns the result over a valid/ready response handshake. Sits between the CPU memory stage and the data memory read port.

Parameters:
ADDR_W, 12, byte address width; word index is ADDR_W-2 bits (1024 words)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  load request valid
req_ready  output  1  unit can accept a request
req_addr  input  ADDR_W  byte address
req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
req_signed  input  1  1 sign-extend (lb/lh), 0 zero-extend (lbu/lhu)
resp_valid  output  1  load result valid
resp_ready  input  1  consumer accepts result
resp_data  output  32  extended load result
mem_rd_en  output  1  memory read active this cycle
mem_addr  output  ADDR_W-2  word index to memory
mem_rdata  input  32  memory word, combinational from mem_addr

Behaviour:
Clocking and reset:
- One clock domain. Reset is asynchronous and active-high.
- While rst=1: state=IDLE, resp_valid=0, resp_data=0, internal addr/size/signed/lo/hi registers=0.
- rst asserted mid-transaction drops the transaction; no response is ever produced for it.

States:
- IDLE: req_ready=1, mem_rd_en=0, mem_addr=0. On req_valid&&req_ready, latch addr, size, signed -> RD0.
- RD0: req_ready=0, mem_rd_en=1, mem_addr=addr[ADDR_W-1:2]. Capture mem_rdata into lo at clock edge.
  - Next state is RD1 if the access crosses a word: halfword with addr[1:0]=11, or word with addr[1:0]!=00.
  - Otherwise next state is RESP.
- RD1: mem_rd_en=1, mem_addr=addr[ADDR_W-1:2]+1, wrapping modulo 2^(ADDR_W-2) (word 1023 -> 0). Capture mem_rdata into hi -> RESP.
- RESP: resp_valid=1, resp_data stable until handshake. On resp_ready=1 -> IDLE, resp_valid=0 next cycle.

Handshake:
- req_ready is 1 only in IDLE; no request is accepted while one is outstanding.
- A request presented during RESP with resp_ready=1 is taken on the following IDLE cycle.

Extraction:
- Form 64-bit {hi,lo}; hi=0 for non-crossing accesses. Shift right by 8*addr[1:0].
- Take the low 8/16/32 bits per size.
- Extend to 32 bits: replicate the top bit of the taken field if signed=1, else zeros. Word loads ignore signed.
- resp_data is registered on the RD0->RESP or RD1->RESP transition.

Latency:
- Accept edge = cycle 0. Aligned access: resp_valid=1 in cycle 2. Crossing access: resp_valid=1 in cycle 3.
- Additional cycles accrue only from resp_ready backpressure.

Boundaries:
- Memory contents changing during RESP do not affect the held resp_data.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Aligned word: mem[5]=0xDEADBEEF; req addr=0x014, size=10 -> resp_data=0xDEADBEEF, resp_valid in cycle 2, mem_addr=5 in cycle 1.
- Signed/unsigned byte: mem[2]=0x80FF7F01; lb at 0x00B -> 0xFFFFFF80; lbu at 0x00B -> 0x00000080; lb at 0x009 -> 0x0000007F.
- Halfword: same word; lh at 0x00A -> 0xFFFF80FF. Crossing lhu at 0x00B with mem[3]=0x000000AA -> 0x0000AA80, resp_valid in cycle 3, mem_addr 2 then 3.
- Unaligned word with wrap: mem[1023]=0x44332211, mem[0]=0x88776655; lw at 0xFFE -> 0x66554433, mem_addr 1023 then 0.
- Backpressure: resp_ready=0 for 4 cycles in RESP -> resp_valid and resp_data held, req_ready=0; resp_ready=1 -> IDLE, req_ready=1 next cycle.
- Reset mid-op: assert rst asynchronously during RD1 -> resp_valid=0, req_ready=1 immediately after release; no response emitted; next request completes normally.

Source files
------------

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - byte/halfword/word load reader for the word-organised data memory
module dm_load_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       lo_q;
    logic              crossing;

    // A halfword at lane 3, or any word not on lane 0, spills into the next word.
    assign crossing = ((size_q == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));

    // Shift the {hi,lo} pair down to the addressed byte, then trim and extend.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sgn);
        logic [63:0] sh;
        logic [31:0] r;
        sh = pair >> {off, 3'b000};
        case (size)
            2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = sh[31:0];
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake/memory-port outputs.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = RD0;
                end
            end
            RD0: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q[ADDR_W-1:2];
                state_nx  = crossing ? RD1 : RESP;
            end
            RD1: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q[ADDR_W-1:2] + WORD_W'(1);
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, low-word capture and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            lo_q      <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                    end
                end
                RD0: begin
                    lo_q <= mem_rdata;
                    if (!crossing) begin
                        resp_data <= extract({32'h0, mem_rdata}, addr_q[1:0], size_q, signed_q);
                    end
                end
                RD1: begin
                    resp_data <= extract({mem_rdata, lo_q}, addr_q[1:0], size_q, signed_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - randomized self-checking bench for dm_load_unit
module tb_dm_load_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    int total = 0;
    int bad   = 0;

    dm_load_unit #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_bytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    // Reference: gather bytes little-endian from a 4096-byte circular space, then extend.
    function automatic logic [31:0] ref_load(input int a, input int sz, input bit sg);
        logic [31:0] v;
        logic [31:0] w;
        logic [7:0]  b;
        int n;
        int ba;
        n = size_bytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            ba = (a + i) % 4096;
            w  = mem[ba / 4];
            b  = w[8 * (ba % 4) +: 8];
            v  = v | (32'(b) << (8 * i));
        end
        if (sg && n < 4 && v[8 * n - 1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic do_load(input int a, input int sz, input bit sg,
                           input logic [31:0] exp, input int stall);
        int n;
        int lat;
        int cyc;
        int w0;
        logic [31:0] save;
        n   = size_bytes(sz);
        lat = ((a % 4) + n > 4) ? 3 : 2;
        w0  = (a / 4) % 1024;
        req_addr   = 12'(a);
        req_size   = 2'(sz);
        req_signed = sg;
        req_valid  = 1'b1;
        resp_ready = (stall == 0);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid  = 1'b0;
        req_addr   = 12'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        check("rd0_en", 32'(mem_rd_en), 32'd1);
        check("rd0_addr", 32'(mem_addr), 32'(w0));
        check("rd0_busy", 32'(req_ready), 32'd0);
        tick();
        cyc = 2;
        if (lat == 3) begin
            check("rd1_en", 32'(mem_rd_en), 32'd1);
            check("rd1_addr", 32'(mem_addr), 32'((w0 + 1) % 1024));
            check("rd1_no_resp", 32'(resp_valid), 32'd0);
            tick();
            cyc = 3;
        end
        while (!resp_valid && cyc < 8) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("resp_data", resp_data, exp);
        check("resp_busy", 32'(req_ready), 32'd0);
        if (stall > 0) begin
            save    = mem[w0];
            mem[w0] = ~save;
            repeat (stall) begin
                tick();
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_data", resp_data, exp);
                check("hold_busy", 32'(req_ready), 32'd0);
            end
            mem[w0]    = save;
            resp_ready = 1'b1;
        end
        tick();
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int a;
        int sz;
        bit sg;
        int st;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_signed = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", resp_data, 32'h0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        rst = 1'b0;
        tick();

        mem[5]    = 32'hDEADBEEF;
        mem[2]    = 32'h80FF7F01;
        mem[3]    = 32'h000000AA;
        mem[1023] = 32'h44332211;
        mem[0]    = 32'h88776655;
        do_load(12'h014, 2, 1'b0, 32'hDEADBEEF, 0);
        do_load(12'h00B, 0, 1'b1, 32'hFFFFFF80, 0);
        do_load(12'h00B, 0, 1'b0, 32'h00000080, 0);
        do_load(12'h009, 0, 1'b1, 32'h0000007F, 0);
        do_load(12'h00A, 1, 1'b1, 32'hFFFF80FF, 0);
        do_load(12'h00B, 1, 1'b0, 32'h0000AA80, 0);
        do_load(12'hFFE, 2, 1'b1, 32'h66554433, 0);
        do_load(12'hFFF, 3, 1'b0, 32'h88776655 >> 0 == 0 ? 32'h0 : 32'h77665544, 0);
        do_load(12'h014, 2, 1'b0, 32'hDEADBEEF, 4);

        // Reset during RD1 of a crossing halfword.
        req_addr   = 12'h00B;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("rd1_before_rst", 32'(mem_addr), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(resp_valid), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_data", resp_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rel_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            tick();
            check("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        do_load(12'h00B, 1, 1'b0, 32'h0000AA80, 0);

        for (int k = 0; k < 150; k++) begin
            a  = $urandom_range(4095);
            sz = $urandom_range(3);
            sg = 1'($urandom);
            st = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
            do_load(a, sz, sg, ref_load(a, sz, sg), st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
